// File: rtl/signed_mult_arbiter.sv
// Round-robin arbiter that shares one pipelined signed multiplier among NUM_REQ
// requesters and routes each registered product back to its issuer.
module signed_mult_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MULT_LAT = 1,
  parameter int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*15-1:0] req_dataa,
  input  logic [NUM_REQ*9-1:0]  req_datab,
  output logic [14:0]           mult_dataa,
  output logic [8:0]            mult_datab,
  input  logic [23:0]           mult_result,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [ID_W-1:0]       rsp_id,
  output logic [23:0]           rsp_result,
  output logic                  busy
);

  localparam int STAGES = MULT_LAT + 1;

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } tag_t;

  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [14:0]     dataa_q;
  logic [8:0]      datab_q;
  tag_t            tag_q [STAGES];

  logic            grant_vld;
  logic [ID_W-1:0] grant_id;
  logic [ID_W:0]   cand;

  // Search from rr_ptr upward, wrapping at NUM_REQ; first valid requester wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
      if (!grant_vld && req_valid[cand[ID_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_id  = cand[ID_W-1:0];
      end
    end
    // NOTE: the grant is gated by the raw reset so no handshake completes in a reset cycle.
    if (!reset_n) grant_vld = 1'b0;
  end

  always_comb begin
    req_ready = '0;
    if (grant_vld) req_ready[grant_id] = 1'b1;
    rr_ptr_d = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rr_ptr_q <= '0;
      dataa_q  <= '0;
      datab_q  <= '0;
      // NOTE: every tag stage is cleared so in-flight operations never produce a response.
      for (int s = 0; s < STAGES; s++) tag_q[s] <= '0;
    end else begin
      tag_q[0] <= '{vld: grant_vld, id: grant_id};
      for (int s = 1; s < STAGES; s++) tag_q[s] <= tag_q[s-1];
      if (grant_vld) begin
        rr_ptr_q <= rr_ptr_d;
        dataa_q  <= req_dataa[grant_id*15 +: 15];
        datab_q  <= req_datab[grant_id*9 +: 9];
      end
    end
  end

  assign mult_dataa = dataa_q;
  assign mult_datab = datab_q;
  assign rsp_id     = tag_q[MULT_LAT].id;
  assign rsp_result = mult_result;

  always_comb begin
    rsp_valid = '0;
    if (tag_q[MULT_LAT].vld) rsp_valid[tag_q[MULT_LAT].id] = 1'b1;
    busy = grant_vld;
    for (int s = 0; s < STAGES; s++) busy = busy | tag_q[s].vld;
  end

endmodule

// File: tb/tb_signed_mult_arbiter.sv
// Directed and scoreboarded random checks of signed_mult_arbiter with a
// behavioural pipelined multiplier attached to its operand/result ports.
module tb_signed_mult_arbiter;

  localparam int NREQ = 4;
  localparam int LAT  = 1;
  localparam int IDW  = 2;

  logic              clock = 1'b0;
  logic              reset_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*15-1:0] req_dataa;
  logic [NREQ*9-1:0] req_datab;
  logic [14:0]       mult_dataa;
  logic [8:0]        mult_datab;
  logic [23:0]       mult_result;
  logic [NREQ-1:0]   rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [23:0]       rsp_result;
  logic              busy;

  always #5 clock = ~clock;

  signed_mult_arbiter #(.NUM_REQ(NREQ), .MULT_LAT(LAT), .ID_W(IDW)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_dataa  (req_dataa),
    .req_datab  (req_datab),
    .mult_dataa (mult_dataa),
    .mult_datab (mult_datab),
    .mult_result(mult_result),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .busy       (busy)
  );

  // External multiplier: registered product, LAT cycles from operands to result.
  wire signed [23:0] prod_w = $signed(mult_dataa) * $signed(mult_datab);
  logic signed [23:0] mpipe [LAT];
  always_ff @(posedge clock) begin
    mpipe[0] <= prod_w;
    for (int s = 1; s < LAT; s++) mpipe[s] <= mpipe[s-1];
  end
  assign mult_result = mpipe[LAT-1];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  logic signed [14:0] opa [NREQ];
  logic signed [8:0]  opb [NREQ];

  task automatic drive(input logic [NREQ-1:0] v);
    req_valid = v;
    for (int i = 0; i < NREQ; i++) begin
      req_dataa[15*i +: 15] = opa[i];
      req_datab[9*i +: 9]   = opb[i];
    end
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive('0);
    tick();
    reset_n = 1'b1;
  endtask

  typedef struct {
    int          due;
    int          id;
    logic [23:0] prod;
  } exp_t;

  exp_t            sb [$];
  int              exp_prod [NREQ];
  int              m_ptr, cyc, g, idx;
  logic [NREQ-1:0] v, exp_rdy, pend;
  logic            exp_busy;

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      opa[i] = '0;
      opb[i] = '0;
    end

    // Reset state, with requests present during reset.
    reset_n = 1'b0;
    drive(4'hF);
    check("rst_ready", 24'(req_ready), 24'(4'b0000));
    tick();
    drive('0);
    tick();
    reset_n = 1'b1;
    drive('0);
    check("rst_rsp_valid", 24'(rsp_valid), 24'(4'b0000));
    check("rst_rsp_id", 24'(rsp_id), 24'(2'd0));
    check("rst_busy", 24'(busy), 24'(1'b0));
    check("rst_mult_a", 24'(mult_dataa), 24'(15'd0));
    check("rst_mult_b", 24'(mult_datab), 24'(9'd0));

    // Single request from requester 2: 100 * -3.
    opa[2] = 15'(100);
    opb[2] = 9'(-3);
    drive(4'b0100);
    check("single_ready", 24'(req_ready), 24'(4'b0100));
    check("single_busy_issue", 24'(busy), 24'(1'b1));
    tick();
    drive('0);
    check("single_mult_a", 24'(mult_dataa), 24'(15'd100));
    check("single_mult_b", 24'(mult_datab), 24'(9'h1FD));
    check("single_early_rsp", 24'(rsp_valid), 24'(4'b0000));
    check("single_busy_flight", 24'(busy), 24'(1'b1));
    tick();
    drive('0);
    check("single_rsp_valid", 24'(rsp_valid), 24'(4'b0100));
    check("single_rsp_id", 24'(rsp_id), 24'(2'd2));
    check("single_rsp_result", rsp_result, 24'(-300));
    tick();
    drive('0);
    check("single_busy_after", 24'(busy), 24'(1'b0));
    check("single_rsp_after", 24'(rsp_valid), 24'(4'b0000));

    // All requesters valid continuously: rotation 0,1,2,3 and range extremes.
    do_reset();
    opa[0] = 15'(-16384); opb[0] = 9'(-256);
    opa[1] = 15'(16383);  opb[1] = 9'(255);
    opa[2] = 15'(100);    opb[2] = 9'(-3);
    opa[3] = 15'(-1);     opb[3] = 9'(1);
    exp_prod[0] = 4194304;
    exp_prod[1] = 4177665;
    exp_prod[2] = -300;
    exp_prod[3] = -1;
    for (int c = 0; c < 10; c++) begin
      drive(4'hF);
      check("rr_ready", 24'(req_ready), 24'(4'b0001 << (c % 4)));
      check("rr_busy", 24'(busy), 24'(1'b1));
      if (c >= 2) begin
        check("rr_rsp_valid", 24'(rsp_valid), 24'(4'b0001 << ((c - 2) % 4)));
        check("rr_rsp_id", 24'(rsp_id), 24'((c - 2) % 4));
        check("rr_rsp_result", rsp_result, 24'(exp_prod[(c - 2) % 4]));
      end
      tick();
    end
    for (int c = 0; c < 3; c++) begin
      drive('0);
      tick();
    end

    // Fairness: requester 1 always valid, requester 3 pulsed.
    do_reset();
    opa[1] = 15'(7);  opb[1] = 9'(2);
    opa[3] = 15'(-9); opb[3] = 9'(3);
    drive(4'b0010); check("fair_c0", 24'(req_ready), 24'(4'b0010)); tick();
    drive(4'b0010); check("fair_c1", 24'(req_ready), 24'(4'b0010)); tick();
    drive(4'b1010); check("fair_c2", 24'(req_ready), 24'(4'b1000)); tick();
    drive(4'b1010); check("fair_c3", 24'(req_ready), 24'(4'b0010)); tick();
    drive(4'b1010); check("fair_c4", 24'(req_ready), 24'(4'b1000)); tick();
    drive(4'b0010); check("fair_c5", 24'(req_ready), 24'(4'b0010)); tick();
    for (int c = 0; c < 3; c++) begin
      drive('0);
      tick();
    end

    // Reset while three operations are in flight.
    do_reset();
    opa[0] = 15'(11); opb[0] = 9'(5);
    opa[1] = 15'(12); opb[1] = 9'(6);
    opa[2] = 15'(13); opb[2] = 9'(7);
    drive(4'b0001); check("midrst_issue0", 24'(req_ready), 24'(4'b0001)); tick();
    drive(4'b0010); check("midrst_issue1", 24'(req_ready), 24'(4'b0010)); tick();
    drive(4'b0100); check("midrst_issue2", 24'(req_ready), 24'(4'b0100)); tick();
    reset_n = 1'b0;
    drive(4'b0111);
    check("midrst_ready_in_reset", 24'(req_ready), 24'(4'b0000));
    tick();
    reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      drive('0);
      check("midrst_no_rsp", 24'(rsp_valid), 24'(4'b0000));
      check("midrst_busy", 24'(busy), 24'(1'b0));
      tick();
    end
    check("midrst_mult_a", 24'(mult_dataa), 24'(15'd0));
    drive(4'hF);
    check("midrst_next_grant", 24'(req_ready), 24'(4'b0001));
    tick();
    for (int c = 0; c < 3; c++) begin
      drive('0);
      tick();
    end

    // Idle: operands hold the last issued pair (requester 3: -5 * 7).
    opa[3] = 15'(-5); opb[3] = 9'(7);
    drive(4'b1000);
    check("idle_issue", 24'(req_ready), 24'(4'b1000));
    tick();
    drive('0);
    tick();
    drive('0);
    check("idle_last_rsp", 24'(rsp_valid), 24'(4'b1000));
    check("idle_last_result", rsp_result, 24'(-35));
    tick();
    for (int c = 0; c < 20; c++) begin
      drive('0);
      check("idle_ready", 24'(req_ready), 24'(4'b0000));
      check("idle_rsp", 24'(rsp_valid), 24'(4'b0000));
      check("idle_busy", 24'(busy), 24'(1'b0));
      check("idle_hold_a", 24'(mult_dataa), 24'(15'h7FFB));
      check("idle_hold_b", 24'(mult_datab), 24'(9'd7));
      tick();
    end

    // Random valid patterns against an arbitration model and response scoreboard.
    do_reset();
    m_ptr = 0;
    cyc   = 0;
    pend  = '0;
    sb.delete();
    for (int n = 0; n < 3010; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i]) begin
          opa[i] = 15'($urandom);
          opb[i] = 9'($urandom);
        end
      end
      v = (n < 3000) ? 4'($urandom) : 4'b0000;
      drive(v);
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (g < 0 && v[idx[1:0]]) g = idx;
      end
      exp_rdy  = (g < 0) ? 4'b0000 : (4'b0001 << g);
      exp_busy = (sb.size() != 0) || (g >= 0);
      check("rnd_ready", 24'(req_ready), 24'(exp_rdy));
      check("rnd_busy", 24'(busy), 24'(exp_busy));
      if (sb.size() != 0 && sb[0].due == cyc) begin
        check("rnd_rsp_valid", 24'(rsp_valid), 24'(4'b0001 << sb[0].id));
        check("rnd_rsp_id", 24'(rsp_id), 24'(sb[0].id));
        check("rnd_rsp_result", rsp_result, sb[0].prod);
        void'(sb.pop_front());
      end else begin
        check("rnd_no_rsp", 24'(rsp_valid), 24'(4'b0000));
      end
      if (g >= 0) begin
        sb.push_back('{due: cyc + LAT + 1, id: g, prod: 24'(int'(opa[g]) * int'(opb[g]))});
        m_ptr = (g + 1) % NREQ;
      end
      pend = v & ~exp_rdy;
      tick();
      cyc++;
    end
    check("rnd_drained", 24'(sb.size()), 24'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/signed_mult_arbiter.md
Name: signed_mult_arbiter

Overview:
Round-robin arbiter and sequencer that shares one pipelined signed_multiplier (15-bit x 9-bit signed, 24-bit registered result) among NUM_REQ requesters in the Reed-Solomon decoder datapath. It accepts at most one operand pair per cycle and registers it onto the multiplier inputs. It tracks the fixed multiplier latency with a tag pipeline and returns each product to the issuing requester as a one-hot response strobe. The multiplier is instantiated outside this block; this block drives its operand ports and consumes its result.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
MULT_LAT, 1, clock cycles from multiplier operand ports to result port (1..4)
ID_W, 2, requester index width, equal to clog2(NUM_REQ)

Ports:
clock  input  1  system clock; all logic on its rising edge
reset_n  input  1  synchronous active-low reset
req_valid  input  NUM_REQ  per-requester operand-valid
req_ready  output  NUM_REQ  per-requester grant; one-hot or zero
req_dataa  input  NUM_REQ*15  packed signed multiplicands; requester i uses bits [15i+14:15i]
req_datab  input  NUM_REQ*9  packed signed multipliers; requester i uses bits [9i+8:9i]
mult_dataa  output  15  to multiplier dataa
mult_datab  output  9  to multiplier datab
mult_result  input  24  from multiplier result
rsp_valid  output  NUM_REQ  one-hot product-valid strobe, one cycle
rsp_id  output  ID_W  index of the requester owning the current rsp_result
rsp_result  output  24  signed product; combinational pass-through of mult_result
busy  output  1  high while any accepted operation has no response yet

Behaviour:
- Reset: synchronous, active-low; sampled only on the clock edge. When asserted:
  - rr_ptr = 0, mult_dataa/mult_datab = 0, tag pipeline cleared, rsp_valid = 0, rsp_id = 0, busy = 0.
  - req_ready = 0 for the entire cycle in which reset_n is low.
- Reset mid-operation: all in-flight tags are discarded. No rsp_valid for any operation accepted before reset, even though the multiplier still produces stale results.
- Arbitration: combinational round-robin.
  - Search starts at rr_ptr, wraps modulo NUM_REQ; the first i with req_valid[i]=1 gets req_ready[i]=1.
  - At most one grant per cycle. No grant when no requester is valid.
- Handshake: a transfer occurs when req_valid[i] && req_ready[i].
  - Requesters hold valid and operands stable until granted.
  - Deasserting valid before grant is permitted; nothing is issued for it.
- On a transfer from requester g:
  - mult_dataa <= req_dataa[g], mult_datab <= req_datab[g].
  - rr_ptr <= (g+1) mod NUM_REQ.
  - Stage 0 of the tag pipe <= {1, g}.
- With no transfer: operand registers hold their value, stage 0 valid <= 0, rr_ptr holds.
- Tag pipeline: MULT_LAT+1 stages of {valid, id}, shifted every cycle.
  - Output stage drives rsp_id and rsp_valid = valid ? (1 << id) : 0.
  - Latency: transfer at edge k gives rsp_valid during cycle k+1+MULT_LAT, aligned with mult_result for those operands.
- Throughput: one issue per cycle sustained. Back-to-back issues from the same or different requesters are allowed.
- No backpressure on responses. Requesters must accept rsp_valid the cycle it appears.
- Arithmetic: the block does not modify operands. rsp_result equals mult_result bit-for-bit (two's complement; full range -16384*-256 = +4194304 fits in 24 bits).
- busy = OR of all tag-pipe valid bits, OR any transfer this cycle.
- Simultaneous issue and response in the same cycle are independent and both occur.
- rr_ptr update uses the granted index only. A requester that never drops valid cannot starve others: maximum wait is NUM_REQ-1 grants.

Test Plan:
- Single request, MULT_LAT=1: reset, then req_valid[2]=1 with dataa=100, datab=-3 for one cycle. Expect req_ready=4'b0100 that cycle, mult_dataa=100 / mult_datab=-3 the next cycle, rsp_valid=4'b0100, rsp_id=2, rsp_result=-300 two cycles after the transfer, and busy low afterwards.
- All four requesters valid continuously from reset: grants in order 0,1,2,3,0,1,... one per cycle. Responses return in the same order with products matching a reference model, including -16384*-256 = 4194304 and 16383*255 = 4177665.
- Fairness: requester 1 valid continuously, requester 3 pulsed. Requester 3 is granted within 2 cycles of asserting, and requester 1 is never granted twice in a row while 3 waits.
- Latency sweep MULT_LAT=1..4 with a behavioural multiplier model: rsp_valid appears exactly MULT_LAT+1 cycles after each transfer, with no missing or spurious strobes under random valid patterns over 10k cycles.
- Reset mid-flight: issue 3 operations back-to-back, assert reset_n=0 for one cycle on the edge after the last issue. Expect no rsp_valid afterwards, busy=0, and the next grant going to requester 0 (rr_ptr reset).
- Idle: req_valid=0 for 20 cycles. Expect req_ready=0, rsp_valid=0, busy=0, and mult_dataa/mult_datab held at their last issued values.
